apb3_master_bridge: RTL and testbench

APB3_MASTER_BRIDGE -- requirements
Module: apb3_master_bridge

---
 rtl/apb3_master_bridge.sv | 124 ++++++++++++
 tb/tb_apb3_master_bridge.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb3_master_bridge.sv
// APB3 master bridge: turns a valid/ready request into one APB3 transfer and
// returns a single-cycle completion strobe, aborting with an error if PREADY never arrives.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// SETUP  | PSEL high, PENABLE low, one cycle
// ACCESS | PSEL and PENABLE high, waiting for PREADY or timeout
// RESP   | rsp_valid strobe, bus released
module apb3_master_bridge #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_ready_d, psel_d, penable_d, pwrite_d;
    logic [31:0]      paddr_d, pwdata_d, rsp_rdata_d;
    logic             rsp_valid_d, rsp_err_d, rsp_timeout_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pwrite_d      = PWRITE;
        paddr_d       = PADDR;
        pwdata_d      = PWDATA;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    pwrite_d = req_write;
                    paddr_d  = req_addr;
                    pwdata_d = req_wdata;
                    cnt_d    = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // PREADY is checked first so a late slave still completes on the last allowed cycle
                if (PREADY) begin
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = PWRITE ? 32'h0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = 32'h0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
    end

    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready   <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= 32'h0;
            PWDATA      <= 32'h0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'h0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready   <= req_ready_d;
            PSEL        <= psel_d;
            PENABLE     <= penable_d;
            PWRITE      <= pwrite_d;
            PADDR       <= paddr_d;
            PWDATA      <= pwdata_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Self-checking bench for apb3_master_bridge: directed and random transfers
// against a transaction-level model of latency, timeout and response contents.
module tb_apb3_master_bridge;

    localparam int TIMEOUT = 16;

    logic        PCLK = 1'b0;
    logic        PRESERN = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0, PSLVERR = 1'b0;

    int n_chk = 0, n_pass = 0;

    int          obs_acc, obs_lat, obs_bad;
    logic [31:0] obs_rdata;
    logic        obs_err, obs_to;

    apb3_master_bridge #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .PCLK(PCLK), .PRESERN(PRESERN),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    // Transaction-level expectation: the slave stalls 'waits' ACCESS cycles, then readies.
    function automatic void model(input logic wr, input int waits, input logic slverr,
                                  input logic [31:0] prd, output int acc, output logic [31:0] rd,
                                  output logic err, output logic to);
        to  = (waits >= TIMEOUT);
        acc = to ? TIMEOUT : waits + 1;
        rd  = (to || wr) ? 32'h0 : prd;
        err = to || slverr;
    endfunction

    // Drives one request and acts as the APB slave; leaves the bench at an IDLE negedge.
    task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int waits, input logic slverr, input logic [31:0] prd);
        bit done = 0;
        obs_bad = 0; obs_acc = 0; obs_lat = 0;
        obs_rdata = 'x; obs_err = 'x; obs_to = 'x;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        for (int i = 0; i < 10 && req_ready !== 1'b1; i++) @(negedge PCLK);
        if (req_ready !== 1'b1) begin
            obs_bad++;
            req_valid = 1'b0;
            return;
        end
        @(negedge PCLK);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        obs_lat   = 1;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, 1'b0, wr, addr, wdata}) obs_bad++;
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = $urandom;
        for (int i = 0; i < 300; i++) begin
            @(negedge PCLK);
            obs_lat++;
            if (PSEL === 1'b1 && PENABLE === 1'b1) begin
                obs_acc++;
                if ({PWRITE, PADDR, PWDATA} !== {wr, addr, wdata}) obs_bad++;
                PREADY  = (obs_acc == waits + 1);
                PSLVERR = PREADY ? slverr : 1'($urandom);
                PRDATA  = PREADY ? prd : $urandom;
            end else begin
                if (rsp_valid === 1'b1) done = 1;
                else obs_bad++;
                break;
            end
        end
        PREADY = 1'b0; PSLVERR = 1'b0;
        if (!done) begin
            obs_bad++;
            return;
        end
        obs_rdata = rsp_rdata; obs_err = rsp_err; obs_to = rsp_timeout;
        @(negedge PCLK);
        if ({rsp_valid, req_ready, PSEL, PENABLE, rsp_rdata, rsp_err, rsp_timeout}
            !== {1'b0, 1'b1, 1'b0, 1'b0, obs_rdata, obs_err, obs_to}) obs_bad++;
        if ({PWRITE, PADDR, PWDATA} !== {wr, addr, wdata}) obs_bad++;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge PCLK);
        n_chk++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0)
            $display("FAIL reset_outputs: got rdy=%b rv=%b rd=%h err=%b to=%b psel=%b pen=%b pw=%b paddr=%h pwdata=%h, want all 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE, PADDR, PWDATA);
        else n_pass++;
        PRESERN = 1'b1;
        @(negedge PCLK);
        n_chk++;
        if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", req_ready);
        else n_pass++;
    endtask

    task automatic test_write_zero_wait;
        run_xfer(1'b1, 32'h4000_0010, 32'h00FF_00AA, 0, 1'b0, 32'h1234_5678);
        n_chk++;
        if (obs_acc !== 1 || obs_lat !== 3)
            $display("FAIL wr0_timing: got access=%0d latency=%0d want 1/3", obs_acc, obs_lat);
        else n_pass++;
        n_chk++;
        if ({obs_rdata, obs_err, obs_to} !== {32'h0, 1'b0, 1'b0})
            $display("FAIL wr0_rsp: got rdata=%h err=%b to=%b want 0/0/0", obs_rdata, obs_err, obs_to);
        else n_pass++;
        n_chk++;
        if (obs_bad !== 0) $display("FAIL wr0_protocol: got %0d violations want 0", obs_bad);
        else n_pass++;
    endtask

    task automatic test_read_waits;
        run_xfer(1'b0, 32'h4000_0020, 32'h0, 3, 1'b0, 32'hDEAD_BEEF);
        n_chk++;
        if (obs_acc !== 4 || obs_lat !== 6)
            $display("FAIL rd3_timing: got access=%0d latency=%0d want 4/6", obs_acc, obs_lat);
        else n_pass++;
        n_chk++;
        if ({obs_rdata, obs_err, obs_to} !== {32'hDEAD_BEEF, 1'b0, 1'b0})
            $display("FAIL rd3_rsp: got rdata=%h err=%b to=%b want deadbeef/0/0", obs_rdata, obs_err, obs_to);
        else n_pass++;
        n_chk++;
        if (obs_bad !== 0) $display("FAIL rd3_protocol: got %0d violations want 0", obs_bad);
        else n_pass++;
    endtask

    task automatic test_slverr;
        run_xfer(1'b0, 32'h4000_0030, 32'h0, 1, 1'b1, 32'hCAFE_0001);
        n_chk++;
        if ({obs_err, obs_to} !== 2'b10 || obs_acc !== 2 || obs_bad !== 0)
            $display("FAIL slverr_rsp: got err=%b to=%b access=%0d viol=%0d want 1/0/2/0",
                     obs_err, obs_to, obs_acc, obs_bad);
        else n_pass++;
    endtask

    task automatic test_timeout;
        run_xfer(1'b0, 32'h4000_0040, 32'h0, 1000, 1'b0, 32'h5555_AAAA);
        n_chk++;
        if (obs_acc !== TIMEOUT || obs_lat !== TIMEOUT + 2)
            $display("FAIL timeout_cycles: got access=%0d latency=%0d want %0d/%0d",
                     obs_acc, obs_lat, TIMEOUT, TIMEOUT + 2);
        else n_pass++;
        n_chk++;
        if ({obs_rdata, obs_err, obs_to} !== {32'h0, 1'b1, 1'b1} || obs_bad !== 0)
            $display("FAIL timeout_rsp: got rdata=%h err=%b to=%b viol=%0d want 0/1/1/0",
                     obs_rdata, obs_err, obs_to, obs_bad);
        else n_pass++;
        run_xfer(1'b0, 32'h4000_0044, 32'h0, TIMEOUT - 1, 1'b0, 32'h0BAD_F00D);
        n_chk++;
        if (obs_acc !== TIMEOUT || {obs_rdata, obs_err, obs_to} !== {32'h0BAD_F00D, 1'b0, 1'b0} || obs_bad !== 0)
            $display("FAIL ready_last_cycle: got access=%0d rdata=%h err=%b to=%b viol=%0d want %0d/0badf00d/0/0/0",
                     obs_acc, obs_rdata, obs_err, obs_to, obs_bad, TIMEOUT);
        else n_pass++;
    endtask

    task automatic test_random;
        int          e_acc;
        logic [31:0] e_rd;
        logic        e_err, e_to;
        for (int t = 0; t < 24; t++) begin
            logic        wr  = 1'($urandom);
            logic        se  = ($urandom_range(0, 3) == 0);
            int          w   = ($urandom_range(0, 5) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 4)
                                                           : $urandom_range(0, 4);
            logic [31:0] a   = $urandom;
            logic [31:0] wd  = $urandom;
            logic [31:0] prd = $urandom;
            model(wr, w, se, prd, e_acc, e_rd, e_err, e_to);
            run_xfer(wr, a, wd, w, se, prd);
            n_chk++;
            if (obs_acc !== e_acc || obs_lat !== e_acc + 2)
                $display("FAIL rand%0d_timing: got access=%0d latency=%0d want %0d/%0d",
                         t, obs_acc, obs_lat, e_acc, e_acc + 2);
            else n_pass++;
            n_chk++;
            if ({obs_rdata, obs_err, obs_to} !== {e_rd, e_err, e_to})
                $display("FAIL rand%0d_rsp: got rdata=%h err=%b to=%b want %h/%b/%b",
                         t, obs_rdata, obs_err, obs_to, e_rd, e_err, e_to);
            else n_pass++;
            n_chk++;
            if (obs_bad !== 0) $display("FAIL rand%0d_protocol: got %0d violations want 0", t, obs_bad);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        int hs_cyc[3];
        int nhs = 0, nrsp = 0, overlap = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4000_0100; req_wdata = 32'h0;
        PREADY = 1'b1; PSLVERR = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (req_valid && req_ready === 1'b1) begin
                hs_cyc[nhs] = c;
                nhs++;
            end
            if (rsp_valid === 1'b1) nrsp++;
            if (PSEL !== 1'b0 && (req_ready !== 1'b0 || rsp_valid !== 1'b0)) overlap++;
            @(negedge PCLK);
            if (nhs == 3) req_valid = 1'b0;
        end
        PREADY = 1'b0;
        n_chk++;
        if (nhs !== 3 || nrsp !== 3)
            $display("FAIL b2b_count: got handshakes=%0d rsp=%0d want 3/3", nhs, nrsp);
        else n_pass++;
        n_chk++;
        if (nhs == 3 && (hs_cyc[1] - hs_cyc[0] !== 4 || hs_cyc[2] - hs_cyc[1] !== 4))
            $display("FAIL b2b_spacing: got %0d,%0d want 4,4", hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1]);
        else if (nhs != 3)
            $display("FAIL b2b_spacing: got %0d handshakes want 3", nhs);
        else n_pass++;
        n_chk++;
        if (overlap !== 0) $display("FAIL b2b_overlap: got %0d want 0", overlap);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int nrsp = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4000_0200; req_wdata = 32'h7777_8888;
        for (int i = 0; i < 10 && req_ready !== 1'b1; i++) @(negedge PCLK);
        @(negedge PCLK);
        req_valid = 1'b0; PREADY = 1'b0;
        repeat (2) @(negedge PCLK);
        n_chk++;
        if ({PSEL, PENABLE} !== 2'b11) $display("FAIL mid_in_access: got psel/pen=%b%b want 11", PSEL, PENABLE);
        else n_pass++;
        PRESERN = 1'b0;
        @(negedge PCLK);
        n_chk++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0)
            $display("FAIL mid_reset_outputs: got rdy=%b rv=%b psel=%b pen=%b pw=%b paddr=%h pwdata=%h rd=%h, want all 0",
                     req_ready, rsp_valid, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_rdata);
        else n_pass++;
        PRESERN = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge PCLK);
            if (rsp_valid !== 1'b0) nrsp++;
        end
        n_chk++;
        if (nrsp !== 0 || req_ready !== 1'b1)
            $display("FAIL mid_no_rsp: got rsp strobes=%0d ready=%b want 0/1", nrsp, req_ready);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_waits();
        test_slverr();
        test_timeout();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
